// File: rtl/dual_port_memory.sv
// Simple dual-port RAM with byte-lane write enables, registered read, selectable
// read-during-write behaviour and a clear engine that zeroes the array after reset or on request.
module dual_port_memory #(
   parameter int width      = 32,
   parameter int size       = 32,
   parameter int addr_width = $clog2(size),
   parameter int lane_width = 8,
   parameter int rd_mode    = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   output logic                          busy,
   input  logic                          wen,
   input  logic [addr_width-1:0]         waddr,
   input  logic [width-1:0]              wdata,
   input  logic [width/lane_width-1:0]   wbe,
   input  logic                          ren,
   input  logic [addr_width-1:0]         raddr,
   output logic [width-1:0]              rdata,
   output logic                          rvalid,
   output logic                          rejected
);
   localparam int lanes = width / lane_width;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                state, state_nx;
   logic [addr_width-1:0] cnt, cnt_nx;
   logic [width-1:0]      mem [size];
   logic [width-1:0]      old_r, old_w, merged, rd_word;
   logic                  w_ok, r_ok, do_wr, do_rd;

   assign busy     = (state == CLEAR);
   assign w_ok     = int'(waddr) < size;
   assign r_ok     = int'(raddr) < size;
   assign do_wr    = !busy && wen && w_ok;
   assign do_rd    = !busy && ren;
   assign rejected = busy && (wen || ren) && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         CLEAR: begin
            cnt_nx = cnt + 1'b1;
            if (cnt == addr_width'(size - 1)) begin
               state_nx = RUN;
               cnt_nx   = '0;
            end
         end
         RUN: begin
            if (clr) begin
               state_nx = CLEAR;
               cnt_nx   = '0;
            end
         end
         default: begin
            state_nx = CLEAR;
            cnt_nx   = '0;
         end
      endcase
   end

   // merged is the post-write word; it doubles as the write-through read value
   always_comb begin
      old_r  = r_ok ? mem[raddr] : '0;
      old_w  = w_ok ? mem[waddr] : '0;
      merged = old_w;
      for (int i = 0; i < lanes; i++)
         if (wbe[i]) merged[i*lane_width +: lane_width] = wdata[i*lane_width +: lane_width];
      rd_word = old_r;
      if (rd_mode == 1 && do_wr && waddr == raddr) rd_word = merged;
   end

   always_ff @(posedge clk) begin
      if (busy)       mem[cnt]   <= '0;
      else if (do_wr) mem[waddr] <= merged;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata  <= '0;
         rvalid <= 1'b0;
      end else begin
         rvalid <= do_rd;
         if (do_rd) rdata <= rd_word;
      end
   end
endmodule

// File: tb/tb_dual_port_memory.sv
// Randomized bench for dual_port_memory: a word-array reference model tracks
// contents, clear duration and expected read data cycle by cycle.
module tb_dual_port_memory;
   localparam int RD_MODE = 0;
   localparam int SIZE    = 32;

   logic        clk = 1'b0, rst = 1'b1, clr = 1'b0;
   logic        busy, wen = 1'b0, ren = 1'b0, rvalid, rejected;
   logic [4:0]  waddr = '0, raddr = '0;
   logic [31:0] wdata = '0, rdata;
   logic [3:0]  wbe = '0;

   int          n_chk = 0, n_pass = 0;
   logic [31:0] ref_mem [SIZE];
   int          clear_left;
   logic [31:0] last_rd;

   dual_port_memory #(.width(32), .size(SIZE), .lane_width(8), .rd_mode(RD_MODE)) dut (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy), .wen(wen), .waddr(waddr),
      .wdata(wdata), .wbe(wbe), .ren(ren), .raddr(raddr), .rdata(rdata),
      .rvalid(rvalid), .rejected(rejected));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic model_clear();
      for (int i = 0; i < SIZE; i++) ref_mem[i] = 32'h0;
      clear_left = SIZE;
   endtask

   // one clock: drive, check combinational outputs, advance model, check registered outputs
   task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic r, input logic [4:0] ra, input logic c);
      logic [31:0] old, mrg, exp_rd;
      logic        mbusy, exp_rv;
      wen = w; waddr = wa; wdata = wd; wbe = be; ren = r; raddr = ra; clr = c;
      #1;
      mbusy = clear_left > 0;
      chk("busy", 32'(busy), 32'(mbusy));
      chk("rejected", 32'(rejected), 32'(mbusy && (w || r)));
      old = ref_mem[ra];
      mrg = ref_mem[wa];
      for (int i = 0; i < 4; i++) if (be[i]) mrg[i*8 +: 8] = wd[i*8 +: 8];
      exp_rv = !mbusy && r;
      exp_rd = !exp_rv ? last_rd : (RD_MODE == 1 && w && wa == ra) ? mrg : old;
      if (mbusy) clear_left--;
      else begin
         if (w) ref_mem[wa] = mrg;
         if (c) model_clear();
      end
      @(posedge clk); #1;
      chk("rvalid", 32'(rvalid), 32'(exp_rv));
      if (exp_rv) chk("rdata", rdata, exp_rd);
      last_rd = exp_rd;
      wen = 0; ren = 0; clr = 0;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rd(input logic [4:0] a);
      step(0, 0, 0, 0, 1, a, 0);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      step(1, a, d, be, 0, 0, 0);
   endtask

   // async reset pulse; outputs must drop before any clock edge
   task automatic do_reset();
      rst = 1'b1; wen = 1'b1; ren = 1'b1;
      #1;
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h1);
      chk("rst_rejected", 32'(rejected), 32'h0);
      wen = 1'b0; ren = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_clear();
      last_rd = 32'h0;
   endtask

   task automatic count_clear();
      int n = 0;
      while (busy && n < 100) begin idle(); n++; end
      chk("clear_cycles", 32'(n), 32'(SIZE));
   endtask

   initial begin
      logic [4:0] a;
      model_clear();
      last_rd = 32'h0;
      @(posedge clk); #1;
      do_reset();
      // 1: clear duration, all-zero contents
      count_clear();
      for (int i = 0; i < SIZE; i++) rd(5'(i));
      // 2: byte-lane writes
      wr(5, 32'hDEADBEEF, 4'hF);
      wr(5, 32'h000000A5, 4'h1);
      rd(5); chk("lane_merge", rdata, 32'hDEADBEA5);
      wr(5, 32'h12345678, 4'h0);
      rd(5); chk("wbe_zero", rdata, 32'hDEADBEA5);
      // 3: collision
      wr(7, 32'h11111111, 4'hF);
      step(1, 7, 32'h22222222, 4'hC, 1, 7, 0);
      chk("collision", rdata, RD_MODE ? 32'h22221111 : 32'h11111111);
      rd(7); chk("after_collision", rdata, 32'h22221111);
      // 4: boundary addresses, simultaneous independent access
      wr(31, 32'hCAFEF00D, 4'hF);
      wr(0, 32'h0BADC0DE, 4'hF);
      rd(31); rd(0);
      step(1, 9, 32'h99999999, 4'hF, 1, 5, 0);
      rd(9);
      // random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 1), 5'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 1), 5'($urandom), ($urandom_range(0, 59) == 0));
      while (busy) idle();
      // 5: fill, clear, accesses rejected during clear
      for (int i = 0; i < SIZE; i++) wr(5'(i), $urandom | 32'h1, 4'hF);
      step(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < SIZE; i++) step(1, 5'($urandom), $urandom, 4'hF, 1, 5'($urandom), 0);
      chk("busy_after_clr", 32'(busy), 32'h0);
      for (int i = 0; i < SIZE; i++) rd(5'(i));
      // 6: reset at clear count 10 and mid-read
      for (int i = 0; i < 8; i++) wr(5'(i), $urandom, 4'hF);
      step(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) idle();
      do_reset();
      count_clear();
      a = 5'd3;
      wr(a, 32'h5A5A5A5A, 4'hF);
      rd(a);
      do_reset();
      count_clear();
      rd(a);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
